// File: rtl/cycle_sequencer.sv
// Four-phase instruction-cycle sequencer: Q1..Q4 strobes, IR/PC control, bubble and halt handling.
// Latency: strobes are decoded combinationally from the phase register; requests act at the end of Q3/Q4.
// Backpressure: halt freezes the core at an instruction-cycle boundary; resumes at Q1 with state kept.
module cycle_sequencer #(
    parameter int STARTUP_CYCLES = 2,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 halt,
    input  logic                 branch_req,
    input  logic                 skip_req,
    output logic                 clk1,
    output logic                 clk2,
    output logic                 clk3,
    output logic                 clk4,
    output logic                 ir_load,
    output logic                 pc_inc,
    output logic                 pc_load,
    output logic                 exec_valid,
    output logic                 nop_sel,
    output logic                 write_en,
    output logic [CNT_WIDTH-1:0] retired
);

    localparam int STARTUP_CLKS = STARTUP_CYCLES * 4;
    localparam int SU_W = ($clog2(STARTUP_CLKS + 1) < 1) ? 1 : $clog2(STARTUP_CLKS + 1);

    typedef enum logic [1:0] {
        ST_STARTUP = 2'd0,
        ST_RUN     = 2'd1,
        ST_HALT    = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [1:0]      phase;
    logic [SU_W-1:0] su_cnt;
    logic            bubble;
    logic            br_pend;
    logic            sk_pend;

    logic startup_done;
    logic end_q3;
    logic end_q4;

    assign startup_done = (su_cnt == SU_W'(STARTUP_CLKS - 1));
    assign end_q3       = (state == ST_RUN) && (phase == 2'd2);
    assign end_q4       = (state == ST_RUN) && (phase == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_STARTUP;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_STARTUP: if (startup_done)   state_nxt = ST_RUN;
            ST_RUN:     if (end_q4 && halt) state_nxt = ST_HALT;
            ST_HALT:    if (!halt)          state_nxt = ST_RUN;
            default:                        state_nxt = ST_STARTUP;
        endcase
    end

    // Phase wraps to Q1 when leaving RUN, so a resume from HALT always starts a fresh cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase  <= 2'd0;
            su_cnt <= '0;
        end else begin
            phase  <= (state == ST_RUN) ? phase + 2'd1 : 2'd0;
            su_cnt <= (state == ST_STARTUP) ? su_cnt + SU_W'(1) : su_cnt;
        end
    end

    // Requests only count when the executing word is real; the bubble decision lands at the Q4->Q1 edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble  <= 1'b1;
            br_pend <= 1'b0;
            sk_pend <= 1'b0;
            retired <= '0;
        end else begin
            if (end_q3 && !bubble) begin
                br_pend <= branch_req;
                sk_pend <= skip_req;
            end else if (end_q4) begin
                br_pend <= 1'b0;
                sk_pend <= 1'b0;
            end
            if (end_q4) begin
                bubble <= br_pend | sk_pend;
                if (!bubble) begin
                    retired <= retired + CNT_WIDTH'(1);
                end
            end
        end
    end

    always_comb begin
        clk1       = (state == ST_RUN) && (phase == 2'd0);
        clk2       = (state == ST_RUN) && (phase == 2'd1);
        clk3       = (state == ST_RUN) && (phase == 2'd2);
        clk4       = (state == ST_RUN) && (phase == 2'd3);
        ir_load    = clk4;
        pc_inc     = clk2;
        pc_load    = clk4 && br_pend;
        exec_valid = !bubble;
        nop_sel    = bubble;
        write_en   = clk3 && !bubble;
    end

endmodule
